// File: rtl/shift_reg_pkg.sv
// Shared operation encoding for the universal shift register and its helpers.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_RSV6  = 3'b110,
    MODE_RSV7  = 3'b111
  } mode_e;

  // True for every operation that advances the frame counter.
  function automatic logic is_shift_op(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shift/rotate operations within a WIDTH-long frame and pulses frame_done on wrap.
module shift_frame_counter
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     frame_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // clr restarts the frame silently; only an increment out of LAST pulses frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else if (inc) begin
      if (count == LAST) begin
        count      <= '0;
        frame_done <= 1'b1;
      end else begin
        count      <= count + CNT_W'(1);
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift left/right, rotate left/right and parallel load,
// with a per-frame operation counter.
module shift_register_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [MODE_W-1:0]        mode,
  input  logic                     serial_in,
  input  logic [WIDTH-1:0]         load_data,
  output logic [WIDTH-1:0]         q,
  output logic                     serial_out,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] shift_count
);

  mode_e            op;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;
  logic             inc;
  logic             clr;

  assign op = mode_e'(mode);

  // Next register/serial_out value; reserved and hold modes keep state.
  always_comb begin
    q_nxt  = q;
    so_nxt = serial_out;
    inc    = 1'b0;
    clr    = 1'b0;
    if (en) begin
      inc = is_shift_op(op);
      case (op)
        MODE_SHL: begin
          q_nxt  = {q[WIDTH-2:0], serial_in};
          so_nxt = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt  = {serial_in, q[WIDTH-1:1]};
          so_nxt = q[0];
        end
        MODE_ROL: begin
          q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
          so_nxt = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt  = {q[0], q[WIDTH-1:1]};
          so_nxt = q[0];
        end
        MODE_LOAD: begin
          q_nxt = load_data;
          clr   = 1'b1;
        end
        default: begin
          q_nxt  = q;
          so_nxt = serial_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      serial_out <= 1'b0;
    end else begin
      q          <= q_nxt;
      serial_out <= so_nxt;
    end
  end

  shift_frame_counter #(
    .WIDTH(WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .clr        (clr),
    .count      (shift_count),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal (WIDTH=8): directed scenarios plus random ops.
module tb_shift_register_universal;

  localparam int unsigned W = 8;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic [2:0] cnt;
    logic       fd;
    bit   [3:0] pin_mask;   // bit0 q, bit1 so, bit2 cnt, bit3 fd
    logic [7:0] pq;
    logic       pso;
    logic [2:0] pcnt;
    logic       pfd;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       serial_in;
  logic [7:0] load_data;
  logic [7:0] q;
  logic       serial_out;
  logic       frame_done;
  logic [2:0] shift_count;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state, kept as plain integers.
  int mq   = 0;
  int mso  = 0;
  int mcnt = 0;
  int mfd  = 0;

  shift_register_universal #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .serial_in   (serial_in),
    .load_data   (load_data),
    .q           (q),
    .serial_out  (serial_out),
    .frame_done  (frame_done),
    .shift_count (shift_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge yields one observable output state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".q"},   64'(q),           64'(e.q));
      chk({e.tag, ".so"},  64'(serial_out),  64'(e.so));
      chk({e.tag, ".cnt"}, 64'(shift_count), 64'(e.cnt));
      chk({e.tag, ".fd"},  64'(frame_done),  64'(e.fd));
      if (e.pin_mask[0]) chk({e.tag, ".spec_q"},   64'(q),           64'(e.pq));
      if (e.pin_mask[1]) chk({e.tag, ".spec_so"},  64'(serial_out),  64'(e.pso));
      if (e.pin_mask[2]) chk({e.tag, ".spec_cnt"}, 64'(shift_count), 64'(e.pcnt));
      if (e.pin_mask[3]) chk({e.tag, ".spec_fd"},  64'(frame_done),  64'(e.pfd));
    end
  end

  function automatic void advance_frame();
    mcnt = mcnt + 1;
    if (mcnt == int'(W)) begin
      mcnt = 0;
      mfd  = 1;
    end
  endfunction

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic step(input string tag, input bit r, input bit e, input int m,
                      input bit si, input int ld);
    exp_t x;
    @(negedge clk);
    rst       = r;
    en        = e;
    mode      = 3'(m);
    serial_in = si;
    load_data = 8'(ld);
    mfd = 0;
    if (r) begin
      mq = 0; mso = 0; mcnt = 0;
    end else if (e) begin
      case (m)
        1: begin mso = mq / 128; mq = (mq * 2 + int'(si)) % 256;       advance_frame(); end
        2: begin mso = mq % 2;   mq = mq / 2 + int'(si) * 128;         advance_frame(); end
        3: begin mso = mq / 128; mq = (mq * 2) % 256 + mq / 128;       advance_frame(); end
        4: begin mso = mq % 2;   mq = mq / 2 + (mq % 2) * 128;         advance_frame(); end
        5: begin mq = ld % 256; mcnt = 0; end
        default: ;
      endcase
    end
    x.q = 8'(mq); x.so = 1'(mso); x.cnt = 3'(mcnt); x.fd = 1'(mfd);
    x.pin_mask = '0; x.pq = '0; x.pso = 1'b0; x.pcnt = '0; x.pfd = 1'b0;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Attach independent hand-derived expectations to the most recent step.
  task automatic pin(input bit [3:0] mask, input int pq, input bit pso, input int pcnt, input bit pfd);
    exp_t x;
    x = sb.pop_back();
    x.pin_mask = mask;
    x.pq = 8'(pq); x.pso = pso; x.pcnt = 3'(pcnt); x.pfd = pfd;
    sb.push_back(x);
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; en = 1'b0; mode = 3'd0; serial_in = 1'b0; load_data = 8'h00;

    step("rst0", 1, 0, 0, 0, 0);
    step("rst1", 1, 1, 1, 1, 8'h55);
    pin(4'hF, 0, 0, 0, 0);

    // 8 SHLs of 11010011 LSB-first
    pat = 8'b11010011;
    for (int i = 0; i < 8; i++) begin
      step("shl8", 0, 1, 1, pat[i], 0);
      if (i < 7) pin(4'h8, 0, 0, 0, 0);
    end
    pin(4'hD, 8'hCB, 0, 0, 1);

    step("ld_a5", 0, 1, 5, 0, 8'hA5);
    pin(4'h5, 8'hA5, 0, 0, 0);
    step("shl_a5", 0, 1, 1, 0, 0);
    pin(4'h7, 8'h4A, 1, 1, 0);
    step("shr_4a", 0, 1, 2, 1, 0);
    pin(4'h3, 8'hA5, 0, 0, 0);

    step("ld_81", 0, 1, 5, 0, 8'h81);
    step("ror_81", 0, 1, 4, 0, 0);
    pin(4'h3, 8'hC0, 1, 0, 0);
    step("rol_c0", 0, 1, 3, 1, 0);
    step("rol_81", 0, 1, 3, 0, 0);
    pin(4'h3, 8'h03, 1, 0, 0);

    // en low: nothing moves
    for (int i = 0; i < 3; i++) begin
      step("en_low", 0, 0, 1, 1'(i % 2 == 0), 0);
      pin(4'hF, 8'h03, 1, 3, 0);
    end

    // Reset mid-frame discards the partial count
    for (int i = 0; i < 3; i++) step("pre_rst", 0, 1, 1, 1, 0);
    step("mid_rst", 1, 1, 1, 1, 0);
    pin(4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step("post_rst", 0, 1, 1, 1'(i % 2), 0);
      pin(4'h8, 0, 0, 0, 0);
    end
    step("post_rst8", 0, 1, 1, 0, 0);
    pin(4'hC, 0, 0, 0, 1);

    // LOAD restarts the frame
    for (int i = 0; i < 5; i++) step("pre_ld", 0, 1, 1, 0, 0);
    step("ld_ff", 0, 1, 5, 0, 8'hFF);
    pin(4'hD, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step("rol_ff", 0, 1, 3, 0, 0);
      if (i < 7) pin(4'h9, 8'hFF, 0, 0, 0);
    end
    pin(4'hD, 8'hFF, 0, 0, 1);

    // Reset on the frame-completing edge suppresses the pulse
    for (int i = 0; i < 7; i++) step("pre_wrap", 0, 1, 2, 1, 0);
    step("rst_wrap", 1, 1, 2, 1, 0);
    pin(4'hF, 0, 0, 0, 0);

    // Random operations
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
